// File: rtl/shift_seq_ctrl.sv
// Frames a serial bit stream into WIDTH-bit words, LSB first, presented on a valid/ready handshake.
// Latency: the word is valid the cycle after the final qualified bit (data bit, or parity bit with SHIFT_SEQ_PARITY_EN).
// Backpressure: dout holds until dout_ready; start requests while busy are dropped and flagged on sticky oflow.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  input  logic             dout_ready,
  input  logic             oflow_clr,
  output logic             busy,
  output logic             shift_en,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             oflow,
  output logic             perr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic             last_bit;
  logic             handshake;

`ifdef SHIFT_SEQ_PARITY_EN
  // The full word is held in sreg while the parity bit is awaited.
  logic [WIDTH-1:0] sreg;
  assign word_nxt = {din, sreg[WIDTH-1:1]};
`else
  // The newest bit comes straight from din, so only WIDTH-1 bits need storing.
  logic [WIDTH-2:0] sreg;
  assign word_nxt = {din, sreg};
`endif

  assign last_bit  = (state == SHIFT) && din_valid && (bit_cnt == LAST_CNT);
  assign handshake = dout_valid && dout_ready;
  assign busy      = (state != IDLE);
  assign shift_en  = (state == SHIFT) && din_valid;

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: arm on start, count bits, optional parity bit, wait for handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
`ifdef SHIFT_SEQ_PARITY_EN
        if (last_bit) state_nxt = PARITY;
`else
        if (last_bit) state_nxt = DONE;
`endif
      end
`ifdef SHIFT_SEQ_PARITY_EN
      PARITY: begin
        if (din_valid) state_nxt = DONE;
      end
`endif
      DONE: begin
        if (handshake) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and output word; a reset discards any partial frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (din_valid) begin
`ifdef SHIFT_SEQ_PARITY_EN
            sreg <= word_nxt;
`else
            sreg <= word_nxt[WIDTH-1:1];
            if (last_bit) begin
              dout       <= word_nxt;
              dout_valid <= 1'b1;
            end
`endif
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef SHIFT_SEQ_PARITY_EN
        PARITY: begin
          if (din_valid) begin
            dout       <= sreg;
            dout_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (handshake) begin
            dout_valid <= 1'b0;
            bit_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_SEQ_PARITY_EN
  // Even-parity check, loaded with dout and dropped on handshake.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      perr <= 1'b0;
    end else if ((state == PARITY) && din_valid) begin
      perr <= (^sreg) ^ din;
    end else if ((state == DONE) && handshake) begin
      perr <= 1'b0;
    end
  end
`else
  assign perr = 1'b0;
`endif

  // Sticky lost-start flag; a new loss outranks a same-cycle clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      oflow <= 1'b0;
    end else if (start && (state != IDLE)) begin
      oflow <= 1'b1;
    end else if (oflow_clr) begin
      oflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=8).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Scenarios are exercised one after another from a single initial block.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       dout_ready = 1'b0;
  logic       oflow_clr = 1'b0;
  logic       busy;
  logic       shift_en;
  logic [3:0] bit_cnt;
  logic [7:0] dout;
  logic       dout_valid;
  logic       oflow;
  logic       perr;

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .dout_ready (dout_ready),
    .oflow_clr  (oflow_clr),
    .busy       (busy),
    .shift_en   (shift_en),
    .bit_cnt    (bit_cnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .oflow      (oflow),
    .perr       (perr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
`ifdef SHIFT_SEQ_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic do_handshake();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    n_checks++; if (oflow !== 1'b0) begin n_fail++; $display("FAIL reset_oflow: got %b want 0", oflow); end
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr); end
    n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL reset_shift_en: got %b want 0", shift_en); end
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    din = 1'b1;
    din_valid = 1'b1;
    #1;
    n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL idle_shift_en: got %b want 0", shift_en); end
    tick(); tick(); tick();
    din_valid = 1'b0;
    din = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL idle_bit_cnt: got %0d want 0", bit_cnt); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL idle_dout_valid: got %b want 0", dout_valid); end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_armed: got %b want 1", busy); end
    n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL basic_cnt_armed: got %0d want 0", bit_cnt); end
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    n_checks++; if (bit_cnt !== 4'd7) begin n_fail++; $display("FAIL basic_cnt7: got %0d want 7", bit_cnt); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b want 0", dout_valid); end
    din = w[7];
    din_valid = 1'b1;
    #1;
    n_checks++; if (shift_en !== 1'b1) begin n_fail++; $display("FAIL basic_shift_en: got %b want 1", shift_en); end
    tick();
    din_valid = 1'b0;
    din = 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_before_par: got %b want 0", dout_valid); end
    send_bit(1'b0);
`endif
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", dout_valid); end
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL basic_dout: got %h want a5", dout); end
    n_checks++; if (bit_cnt !== 4'd8) begin n_fail++; $display("FAIL basic_cnt_done: got %0d want 8", bit_cnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: got %b want 1", busy); end
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", perr); end
    tick();
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_held: got %b want 1", dout_valid); end
    do_handshake();
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after_hs: got %b want 0", dout_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_hs: got %b want 0", busy); end
    n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL basic_cnt_after_hs: got %0d want 0", bit_cnt); end
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL basic_dout_kept: got %h want a5", dout); end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'hA5;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        din = w[i/2];
        din_valid = 1'b1;
      end else begin
        din = ~w[i/2];
        din_valid = 1'b0;
      end
      tick();
      if (i == 3) begin
        n_checks++; if (bit_cnt !== 4'd2) begin n_fail++; $display("FAIL gaps_cnt_hold: got %0d want 2", bit_cnt); end
      end
      if (i == 9) begin
        n_checks++; if (bit_cnt !== 4'd5) begin n_fail++; $display("FAIL gaps_cnt5: got %0d want 5", bit_cnt); end
      end
    end
    din_valid = 1'b0;
    din = 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
    send_bit(1'b0);
`endif
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid: got %b want 1", dout_valid); end
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL gaps_dout: got %h want a5", dout); end
    do_handshake();
  endtask

  task automatic test_hold_oflow();
    pulse_start();
    send_frame(8'hA5);
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b want 1", dout_valid); end
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL hold_dout: got %h want a5", dout); end
    pulse_start();
    n_checks++; if (oflow !== 1'b1) begin n_fail++; $display("FAIL hold_oflow_set: got %b want 1", oflow); end
    n_checks++; if (bit_cnt !== 4'd8) begin n_fail++; $display("FAIL hold_no_restart_cnt: got %0d want 8", bit_cnt); end
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_after_start: got %b want 1", dout_valid); end
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL hold_dout_after_start: got %h want a5", dout); end
    do_handshake();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got %b want 0", busy); end
    tick(); tick();
    n_checks++; if (oflow !== 1'b1) begin n_fail++; $display("FAIL hold_oflow_sticky: got %b want 1", oflow); end
    oflow_clr = 1'b1;
    tick();
    oflow_clr = 1'b0;
    n_checks++; if (oflow !== 1'b0) begin n_fail++; $display("FAIL hold_oflow_clr: got %b want 0", oflow); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    pulse_start();
    n_checks++; if (oflow !== 1'b1) begin n_fail++; $display("FAIL arst_oflow_pre: got %b want 1", oflow); end
    #3;
    clr_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d want 0", bit_cnt); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL arst_dout: got %h want 00", dout); end
    n_checks++; if (oflow !== 1'b0) begin n_fail++; $display("FAIL arst_oflow: got %b want 0", oflow); end
    tick();
    clr_n = 1'b1;
    tick();
    pulse_start();
    send_frame(8'h3C);
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL arst_new_valid: got %b want 1", dout_valid); end
    n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL arst_new_dout: got %h want 3c", dout); end
    do_handshake();
  endtask

  task automatic test_set_wins();
    pulse_start();
    send_frame(8'h5A);
    n_checks++; if (oflow !== 1'b0) begin n_fail++; $display("FAIL setwins_pre: got %b want 0", oflow); end
    start = 1'b1;
    oflow_clr = 1'b1;
    tick();
    start = 1'b0;
    oflow_clr = 1'b0;
    n_checks++; if (oflow !== 1'b1) begin n_fail++; $display("FAIL setwins_oflow: got %b want 1", oflow); end
    n_checks++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL setwins_dout: got %h want 5a", dout); end
    do_handshake();
    oflow_clr = 1'b1;
    tick();
    oflow_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send_frame(8'hC3);
    n_checks++; if (dout !== 8'hC3) begin n_fail++; $display("FAIL b2b_first: got %h want c3", dout); end
    do_handshake();
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_rearm: got %b want 1", busy); end
    n_checks++; if (oflow !== 1'b0) begin n_fail++; $display("FAIL b2b_oflow: got %b want 0", oflow); end
    send_frame(8'h81);
    n_checks++; if (dout !== 8'h81) begin n_fail++; $display("FAIL b2b_second: got %h want 81", dout); end
    do_handshake();
  endtask

`ifdef SHIFT_SEQ_PARITY_EN
  task automatic test_parity();
    logic [7:0] w;
    w = 8'hA5;
    pulse_start();
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL par_valid_early: got %b want 0", dout_valid); end
    send_bit(1'b0);
    n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL par_valid: got %b want 1", dout_valid); end
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b want 0", perr); end
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL par_dout: got %h want a5", dout); end
    do_handshake();
    pulse_start();
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    send_bit(1'b1);
    n_checks++; if (perr !== 1'b1) begin n_fail++; $display("FAIL par_bad: got %b want 1", perr); end
    do_handshake();
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL par_clr_hs: got %b want 0", perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_gaps();
    test_hold_oflow();
    test_async_reset();
    test_set_wins();
    test_back_to_back();
`ifdef SHIFT_SEQ_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
